// File: rtl/pipeline_ctrl_pkg.sv
// Shared control-bundle definitions for the CU mux and the pipeline registers.
package pipeline_ctrl_pkg;

  localparam int STATUS_W   = 2;
  localparam int ALU_CTRL_W = 2;

  // Seven decoded control fields, 9 bits total, reg_write in the MSB.
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [STATUS_W-1:0]   status_bits;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  pc_src;
  } ctrl_bundle_t;

  // Bubble: nothing architectural is written.
  localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_perf_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module id_ex_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Clear wins; otherwise count up until all-ones and stay there.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with stall (hold) and flush (bubble) control.
// Optional perf counters (bubbles, stalls) enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipeline_reg
  import pipeline_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH      = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic                      reg_write_enable_in,
  input  logic                      mem_write_enable_in,
  input  logic                      mem_to_reg_select_in,
  input  logic                      alu_src_select_in,
  input  logic [STATUS_W-1:0]       status_bits_in,
  input  logic [ALU_CTRL_W-1:0]     alu_control_in,
  input  logic                      pc_src_select_in,
  input  logic [DATA_WIDTH-1:0]     rn_value_in,
  input  logic [DATA_WIDTH-1:0]     rm_value_in,
  input  logic [DATA_WIDTH-1:0]     imm_in,
  input  logic [DATA_WIDTH-1:0]     pc_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  output logic                      valid_out,
  output logic                      reg_write_enable_out,
  output logic                      mem_write_enable_out,
  output logic                      mem_to_reg_select_out,
  output logic                      alu_src_select_out,
  output logic [STATUS_W-1:0]       status_bits_out,
  output logic [ALU_CTRL_W-1:0]     alu_control_out,
  output logic                      pc_src_select_out,
  output logic [DATA_WIDTH-1:0]     rn_value_out,
  output logic [DATA_WIDTH-1:0]     rm_value_out,
  output logic [DATA_WIDTH-1:0]     imm_out,
  output logic [DATA_WIDTH-1:0]     pc_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_out
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      bubble_count,
  output logic [CNT_WIDTH-1:0]      stall_count
`endif
);

  ctrl_bundle_t              ctrl_in;
  ctrl_bundle_t              ctrl_reg;
  logic                      valid_reg;
  logic [DATA_WIDTH-1:0]     rn_reg;
  logic [DATA_WIDTH-1:0]     rm_reg;
  logic [DATA_WIDTH-1:0]     imm_reg;
  logic [DATA_WIDTH-1:0]     pc_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_reg;

  assign ctrl_in = '{reg_write:   reg_write_enable_in,
                     mem_write:   mem_write_enable_in,
                     mem_to_reg:  mem_to_reg_select_in,
                     alu_src:     alu_src_select_in,
                     status_bits: status_bits_in,
                     alu_control: alu_control_in,
                     pc_src:      pc_src_select_in};

  // Priority reset > flush > stall > load; flush keeps data, invalid loads get a NOP bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= CTRL_NOP;
      rn_reg    <= '0;
      rm_reg    <= '0;
      imm_reg   <= '0;
      pc_reg    <= '0;
      rd_reg    <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= CTRL_NOP;
    end else if (!stall) begin
      valid_reg <= valid_in;
      ctrl_reg  <= valid_in ? ctrl_in : CTRL_NOP;
      rn_reg    <= rn_value_in;
      rm_reg    <= rm_value_in;
      imm_reg   <= imm_in;
      pc_reg    <= pc_in;
      rd_reg    <= rd_addr_in;
    end
  end

  assign valid_out             = valid_reg;
  assign reg_write_enable_out  = ctrl_reg.reg_write;
  assign mem_write_enable_out  = ctrl_reg.mem_write;
  assign mem_to_reg_select_out = ctrl_reg.mem_to_reg;
  assign alu_src_select_out    = ctrl_reg.alu_src;
  assign status_bits_out       = ctrl_reg.status_bits;
  assign alu_control_out       = ctrl_reg.alu_control;
  assign pc_src_select_out     = ctrl_reg.pc_src;
  assign rn_value_out          = rn_reg;
  assign rm_value_out          = rm_reg;
  assign imm_out               = imm_reg;
  assign pc_out                = pc_reg;
  assign rd_addr_out           = rd_reg;

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_inc;
  logic stall_inc;

  // A bubble enters on flush or on an unstalled load of an empty slot; the two are mutually exclusive.
  always_comb begin
    bubble_inc = 1'b0;
    stall_inc  = 1'b0;
    if (flush) begin
      bubble_inc = 1'b1;
    end else if (stall) begin
      stall_inc = 1'b1;
    end else if (!valid_in) begin
      bubble_inc = 1'b1;
    end
  end

  id_ex_perf_counter #(.W(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bubble_inc),
    .count (bubble_count)
  );

  id_ex_perf_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );
`endif

endmodule
